// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: sequential instruction fetch with a DEPTH-entry prefetch queue and redirect flush
module if_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc_4,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic {RUN, KILL} state_t;
  state_t state, state_n;
  logic [31:0] fetch_pc, kill_addr;
  logic [31:0] instr_q [DEPTH];
  logic [31:0] pc4_q [DEPTH];
  logic [AW-1:0] head, tail;
  logic push, pop;
  assign mem_req = !rst && (state == KILL || count != FULL);
  assign mem_addr = state == KILL ? kill_addr : fetch_pc;
  assign out_valid = count != '0;
  assign out_instr = out_valid ? instr_q[head] : '0;
  assign out_pc_4 = out_valid ? pc4_q[head] : '0;
  assign push = state == RUN && mem_req && mem_ack && !redirect;
  assign pop = out_valid && out_ready && !redirect;
  // A redirect with a request still open must wait out that request; its ack ends the kill.
  always_comb begin
    state_n = state;
    if (redirect) state_n = (mem_req && !mem_ack) ? KILL : RUN;
    else if (state == KILL && mem_ack) state_n = RUN;
  end
  // Control state: FSM, fetch PC, queue pointers and occupancy; redirect flushes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      kill_addr <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      state <= state_n;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        if (state == RUN) kill_addr <= fetch_pc;
        count <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        if (push) fetch_pc <= fetch_pc + 32'd4;
        if (push) tail <= tail + AW'(1);
        if (pop) head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  // Queue storage; contents only matter while counted as occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[tail] <= mem_rdata;
      pc4_q[tail] <= fetch_pc + 32'd4;
    end
  end
  // Occupancy can never exceed the queue size.
  always_ff @(posedge clk) begin
    if (!rst) assert (count <= FULL) else $error("prefetch queue occupancy exceeds DEPTH");
  end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb_if_prefetch_queue: directed and randomized scoreboard bench for the prefetch queue
module tb_if_prefetch_queue;
  localparam logic [31:0] RPC = 32'h0000_3000;
  logic clk = 0, rst = 1, redirect = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0, mem_rdata = 0;
  logic mem_ack = 0;
  logic mem_req, out_valid;
  logic [31:0] mem_addr, out_instr, out_pc_4;
  logic [2:0] count;
  int fixed_lat = 0, wait_left = 0;
  bit spurious = 0;
  int m_tot = 0, m_pass = 0, s_tot = 0, s_pass = 0, pops = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = RPC, e, prev_addr = 0;
  bit prev_hold = 0;

  if_prefetch_queue #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc_4(out_pc_4),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Memory image: every word address holds a distinct instruction derived from it.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    m_tot++;
    if (act === exp) m_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic schk(input string name, input logic [31:0] act, input logic [31:0] exp);
    s_tot++;
    if (act === exp) s_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Instruction memory: acks after wait_left idle cycles, reloads the latency on each ack or when idle.
  always @(negedge clk) begin
    #1;
    if (mem_req) begin
      if (wait_left <= 0) begin
        mem_ack = 1;
        mem_rdata = instr_of(mem_addr);
        wait_left = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
      end else begin
        mem_ack = 0;
        mem_rdata = $urandom;
        wait_left--;
      end
    end else begin
      mem_ack = spurious && $urandom_range(0, 3) == 0;
      mem_rdata = $urandom;
      wait_left = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
    end
  end

  // Scoreboard: expected stream is sequential PCs from the last reset/redirect target.
  always @(negedge clk) begin
    #2;
    if (prev_hold && !rst) begin
      schk("req_hold", mem_req, 1);
      schk("addr_hold", mem_addr, prev_addr);
    end
    prev_hold = mem_req && !mem_ack && !rst;
    prev_addr = mem_addr;
    if (!rst) schk("valid_vs_count", out_valid, count != '0);
    if (rst || redirect) begin
      exp_q.delete();
      gen_pc = rst ? RPC : redirect_pc;
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      schk("instr", out_instr, instr_of(e));
      schk("pc_4", out_pc_4, e + 32'd4);
      pops++;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
  end

  task automatic do_reset(input int lat);
    @(negedge clk);
    rst = 1;
    redirect = 0;
    out_ready = 0;
    fixed_lat = lat;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    out_ready = 1;
    @(negedge clk);
    #3;
    chk("reset_req", mem_req, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_instr", out_instr, 0);
    chk("reset_pc4", out_pc_4, 0);
    @(negedge clk);
    rst = 0;
    #3;
    chk("first_req", mem_req, 1);
    chk("first_addr", mem_addr, 32'h3000);
    chk("first_valid", out_valid, 0);
    @(negedge clk);
    #3;
    chk("addr_3004", mem_addr, 32'h3004);
    chk("valid_rise", out_valid, 1);
    chk("pc4_3004", out_pc_4, 32'h3004);
    @(negedge clk);
    #3;
    chk("addr_3008", mem_addr, 32'h3008);
    chk("pc4_3008", out_pc_4, 32'h3008);
    @(negedge clk);
    #3;
    chk("pc4_300c", out_pc_4, 32'h300C);

    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      #3;
      chk("fill_count", count, k);
      chk("fill_req", mem_req, 1);
      @(negedge clk);
    end
    #3;
    chk("full_count", count, 4);
    chk("full_req", mem_req, 0);
    @(negedge clk);
    out_ready = 1;
    #3;
    chk("full_pop_req", mem_req, 0);
    @(negedge clk);
    out_ready = 0;
    #3;
    chk("after_pop_count", count, 3);
    chk("after_pop_req", mem_req, 1);
    chk("after_pop_addr", mem_addr, 32'h3010);
    @(negedge clk);
    #3;
    chk("refill_count", count, 4);

    do_reset(3);
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      #3;
      if (k == 0) begin
        chk("rst_full_count", count, 0);
        chk("rst_full_valid", out_valid, 0);
        chk("rst_full_instr", out_instr, 0);
        chk("rst_full_pc4", out_pc_4, 0);
      end
      chk("ws_addr", mem_addr, 32'h3000 + 4 * (k / 4));
      chk("ws_count", count, k / 4);
    end
    @(negedge clk);
    redirect = 1;
    redirect_pc = 32'h3100;
    #3;
    chk("kill_no_ack", mem_ack, 0);
    @(negedge clk);
    redirect = 0;
    #3;
    chk("kill_req", mem_req, 1);
    chk("kill_addr", mem_addr, 32'h3008);
    chk("kill_count", count, 0);
    @(negedge clk);
    fixed_lat = 0;
    #3;
    chk("kill_addr_hold", mem_addr, 32'h3008);
    chk("kill_ack", mem_ack, 1);
    @(negedge clk);
    out_ready = 1;
    #3;
    chk("kill_dropped", count, 0);
    chk("redir_addr", mem_addr, 32'h3100);
    chk("redir_req", mem_req, 1);
    @(negedge clk);
    #3;
    chk("redir_valid", out_valid, 1);
    chk("redir_pc4", out_pc_4, 32'h3104);

    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    redirect = 1;
    redirect_pc = 32'h4000;
    out_ready = 1;
    #3;
    chk("coinc_count", count, 2);
    chk("coinc_ack", mem_ack, 1);
    @(negedge clk);
    redirect = 0;
    #3;
    chk("coinc_flush", count, 0);
    chk("coinc_valid", out_valid, 0);
    chk("coinc_addr", mem_addr, 32'h4000);
    chk("coinc_req", mem_req, 1);
    @(negedge clk);
    #3;
    chk("coinc_count1", count, 1);
    chk("coinc_pc4", out_pc_4, 32'h4004);

    do_reset(0);
    @(negedge clk);
    @(negedge clk);
    fixed_lat = 3;
    @(negedge clk);
    redirect = 1;
    redirect_pc = 32'h5000;
    #3;
    chk("midkill_count", count, 3);
    chk("midkill_no_ack", mem_ack, 0);
    @(negedge clk);
    redirect = 0;
    rst = 1;
    #3;
    chk("midkill_held", mem_addr, 32'h300C);
    chk("midkill_rst_req", mem_req, 0);
    @(negedge clk);
    rst = 0;
    #3;
    chk("midkill_rst_count", count, 0);
    chk("midkill_rst_valid", out_valid, 0);
    chk("midkill_rst_req1", mem_req, 1);
    chk("midkill_rst_addr", mem_addr, 32'h3000);

    fixed_lat = -1;
    spurious = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 299) == 0;
      redirect = !rst && $urandom_range(0, 19) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      redirect_pc = $urandom_range(0, 7) == 0 ? 32'hFFFF_FFF8 : 32'h6000 + 32'(4 * $urandom_range(0, 255));
    end
    @(negedge clk);
    rst = 0;
    redirect = 0;
    spurious = 0;
    @(negedge clk);
    chk("progress", pops > 300, 1);
    $display("%0d/%0d checks passed", m_pass + s_pass, m_tot + s_tot);
    $finish;
  end
endmodule
